// File: rtl/cpu_pkg.sv
// Definitions shared between the CPU control path and the program loader.
package cpu_pkg;

    localparam int INSTR_W  = 16;
    localparam int OPCODE_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        WORD_HI,
        WORD_LO,
        WRITE,
        DONE,
        ERR
    } loader_state_e;

endpackage

// File: rtl/prog_loader.sv
// Receives a length-prefixed big-endian byte stream, packs it into instruction words,
// writes them to instruction memory and then releases the CPU.
module prog_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               rx_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               load_busy,
    output logic               load_done,
    output logic               load_err,
    output logic               cpu_enable
);

    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    loader_state_e      state_q, state_d;
    logic [15:0]        count_q, count_d;
    logic [15:0]        index_q, index_d;
    logic [7:0]         hi_q, hi_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] wdata_q, wdata_d;
    logic [15:0]        len_new;
    logic               xfer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            index_q <= '0;
            hi_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Ready is a pure state decode so the source never sees a combinational loop.
    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            LEN_HI, LEN_LO, WORD_HI, WORD_LO: rx_ready = 1'b1;
            default:                          rx_ready = 1'b0;
        endcase
    end

    assign xfer    = rx_valid & rx_ready;
    assign len_new = {count_q[15:8], rx_data};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        hi_d    = hi_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = LEN_HI;
            end
            LEN_HI: begin
                if (xfer) begin
                    count_d[15:8] = rx_data;
                    state_d       = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    count_d[7:0] = rx_data;
                    if (len_new == 16'd0) begin
                        state_d = DONE;
                    end else if ({1'b0, len_new} > DEPTH) begin
                        state_d = ERR;
                    end else begin
                        index_d = '0;
                        state_d = WORD_HI;
                    end
                end
            end
            WORD_HI: begin
                if (xfer) begin
                    hi_d    = rx_data;
                    state_d = WORD_LO;
                end
            end
            WORD_LO: begin
                // Address and data are captured here so they hold steady after the strobe.
                if (xfer) begin
                    wdata_d = {hi_q, rx_data};
                    addr_d  = index_q[ADDR_W-1:0];
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (index_q == count_q - 16'd1) begin
                    state_d = DONE;
                end else begin
                    index_d = index_q + 16'd1;
                    state_d = WORD_HI;
                end
            end
            DONE, ERR: begin
                if (start) state_d = LEN_HI;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_we    = (state_q == WRITE);
        load_busy  = 1'b0;
        load_done  = (state_q == DONE);
        load_err   = (state_q == ERR);
        cpu_enable = (state_q == DONE);
        case (state_q)
            LEN_HI, LEN_LO, WORD_HI, WORD_LO, WRITE: load_busy = 1'b1;
            default:                                 load_busy = 1'b0;
        endcase
    end

    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: captures every memory write and checks it against hand-computed streams.
module tb_prog_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              load_busy;
    logic              load_done;
    logic              load_err;
    logic              cpu_enable;

    int n_cmp = 0;
    int n_bad = 0;
    int wa[$];
    int wd[$];
    int ready_in_write = 0;

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err),
        .cpu_enable (cpu_enable)
    );

    always #5 clk = ~clk;

    // Pre-edge values: one entry per cycle the write strobe was high.
    always @(posedge clk) begin
        if (imem_we === 1'b1) begin
            wa.push_back(int'(imem_addr));
            wd.push_back(int'(imem_wdata));
            if (rx_ready !== 1'b0) ready_in_write++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic logic [29:0] all_outs();
        return {rx_ready, imem_we, imem_addr, imem_wdata, load_busy, load_done, load_err, cpu_enable};
    endfunction

    initial begin
        int base;
        int bad;
        logic [7:0] stream [8];
        logic [7:0] ib;

        stream[0] = 8'h00; stream[1] = 8'h03; stream[2] = 8'h12; stream[3] = 8'h34;
        stream[4] = 8'hAB; stream[5] = 8'hCD; stream[6] = 8'hF0; stream[7] = 8'h0F;

        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 32'(all_outs()), 32'd0);

        pulse_start();
        chk("len_hi_ready", {31'd0, rx_ready}, 32'd1);
        chk("len_hi_busy", {31'd0, load_busy}, 32'd1);

        // Normal 3-word load, source always valid.
        for (int i = 0; i < 8; i++) send(stream[i], 0);
        chk("w3_we", {31'd0, imem_we}, 32'd1);
        chk("w3_addr", 32'(imem_addr), 32'd2);
        chk("w3_data", 32'(imem_wdata), 32'hF00F);
        chk("w3_ready", {31'd0, rx_ready}, 32'd0);
        chk("w3_done_early", {31'd0, load_done}, 32'd0);
        @(negedge clk);
        chk("done_after_w3", {31'd0, load_done}, 32'd1);
        chk("enable_after_w3", {31'd0, cpu_enable}, 32'd1);
        chk("busy_after_w3", {31'd0, load_busy}, 32'd0);
        chk("n_writes_normal", wa.size(), 32'd3);
        chk("wr0", {wa[0][15:0], wd[0][15:0]}, 32'h0000_1234);
        chk("wr1", {wa[1][15:0], wd[1][15:0]}, 32'h0001_ABCD);
        chk("wr2", {wa[2][15:0], wd[2][15:0]}, 32'h0002_F00F);

        // Restart from DONE, then the same stream with gaps in rx_valid.
        pulse_start();
        chk("restart_enable_drop", {31'd0, cpu_enable}, 32'd0);
        chk("restart_ready", {31'd0, rx_ready}, 32'd1);
        base = wa.size();
        for (int i = 0; i < 8; i++) send(stream[i], int'($urandom_range(0, 3)));
        @(negedge clk);
        chk("gap_done", {31'd0, load_done}, 32'd1);
        chk("gap_n_writes", wa.size() - base, 32'd3);
        chk("gap_wr0", {wa[base][15:0], wd[base][15:0]}, 32'h0000_1234);
        chk("gap_wr1", {wa[base+1][15:0], wd[base+1][15:0]}, 32'h0001_ABCD);
        chk("gap_wr2", {wa[base+2][15:0], wd[base+2][15:0]}, 32'h0002_F00F);

        // Zero-length program.
        pulse_start();
        base = wa.size();
        send(8'h00, 0);
        send(8'h00, 0);
        chk("zero_done", {31'd0, load_done}, 32'd1);
        chk("zero_enable", {31'd0, cpu_enable}, 32'd1);
        repeat (3) @(negedge clk);
        chk("zero_no_write", wa.size(), base);

        // 257 words exceeds a 256-word memory.
        pulse_start();
        send(8'h01, 0);
        send(8'h01, 0);
        chk("ovf_err", {31'd0, load_err}, 32'd1);
        chk("ovf_ready", {31'd0, rx_ready}, 32'd0);
        chk("ovf_enable", {31'd0, cpu_enable}, 32'd0);
        chk("ovf_busy", {31'd0, load_busy}, 32'd0);
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        chk("ovf_holds", {31'd0, load_err}, 32'd1);
        chk("ovf_no_write", wa.size(), base);

        // Exactly 256 words fills the memory; word i = {i, ~i}.
        pulse_start();
        base = wa.size();
        send(8'h01, 0);
        send(8'h00, 0);
        for (int i = 0; i < 256; i++) begin
            ib = 8'(i);
            send(ib, 0);
            send(~ib, 0);
        end
        @(negedge clk);
        chk("full_done", {31'd0, load_done}, 32'd1);
        chk("full_n_writes", wa.size() - base, 32'd256);
        chk("full_last", {wa[base+255][15:0], wd[base+255][15:0]}, 32'h00FF_FF00);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            ib = 8'(i);
            if (wa[base+i] != i || wd[base+i] != int'({ib, ~ib})) bad++;
        end
        chk("full_contents_bad", bad, 32'd0);

        // Start while busy is ignored; reset mid-load aborts.
        pulse_start();
        base = wa.size();
        for (int i = 0; i < 4; i++) send(stream[i], 0);
        @(negedge clk);
        pulse_start();
        chk("busy_start_ignored", {31'd0, load_busy}, 32'd1);
        send(8'hAB, 0);
        send(8'hCD, 0);
        chk("busy_wr_addr", 32'(imem_addr), 32'd1);
        chk("busy_wr_data", 32'(imem_wdata), 32'hABCD);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'hF0;
        #2 reset = 1'b1;
        #1 chk("midload_reset_outputs", 32'(all_outs()), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        rx_valid = 1'b0;
        chk("after_reset_busy", {31'd0, load_busy}, 32'd0);
        chk("after_reset_enable", {31'd0, cpu_enable}, 32'd0);
        chk("after_reset_writes", wa.size() - base, 32'd2);

        chk("ready_in_write", ready_in_write, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer end of the CPU instruction-memory interface: receives a program as a byte stream over a valid/ready handshake and packs it into 16-bit instruction words.
- Writes the words into instruction memory through a single write port.
- Holds the CPU's `enable` low while loading, then raises it so the core starts executing from address 0.
- Sits between the host link (UART/test bench byte source) and `Team4_CPU` + instruction memory.

Parameters:
- ADDR_W, 8, instruction-memory address width; capacity DEPTH = 2^ADDR_W words.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse to begin a load; honoured only in IDLE, DONE or ERR
- rx_valid  input  1  byte-source data valid
- rx_data  input  8  byte from source
- rx_ready  output  1  loader can accept a byte this cycle
- imem_we  output  1  instruction-memory write strobe
- imem_addr  output  ADDR_W  write address
- imem_wdata  output  16  instruction word
- load_busy  output  1  high in any load state
- load_done  output  1  high in DONE
- load_err  output  1  high in ERR
- cpu_enable  output  1  drives `Team4_CPU` enable; high only in DONE

Behaviour:
- Reset (async, active-high) forces state IDLE. Registers clear: count, index, hi-byte, word register.
- Reset values of all outputs are 0.
- Stream format:
  - 2-byte big-endian word count N.
  - Then N words, each high byte first.
- Byte transfer occurs on a clock edge when rx_valid & rx_ready. rx_ready is high in LEN_HI, LEN_LO, WORD_HI and WORD_LO only.
- rx_ready is decoded from state only; it never depends combinationally on rx_valid.
- States and transitions:
  - IDLE: start -> LEN_HI.
  - LEN_HI: on transfer, latch count[15:8] -> LEN_LO.
  - LEN_LO: on transfer, latch count[7:0]. Then:
    - if N == 0 -> DONE;
    - if N > DEPTH -> ERR;
    - else index = 0 -> WORD_HI.
  - WORD_HI: on transfer, latch hi byte -> WORD_LO.
  - WORD_LO: on transfer, word = {hi, rx_data} -> WRITE.
  - WRITE: imem_we = 1 for exactly one cycle, with imem_addr = index[ADDR_W-1:0] and imem_wdata = word. Then:
    - if index == N-1 -> DONE;
    - else index + 1 -> WORD_HI.
  - DONE: cpu_enable = 1, load_done = 1. Holds indefinitely. start -> LEN_HI, and cpu_enable drops on that same edge.
  - ERR: load_err = 1, cpu_enable = 0, rx_ready = 0. start -> LEN_HI.
- Outputs are Moore, decoded from registered state/data. imem_addr and imem_wdata hold their last values outside WRITE; only imem_we qualifies them.
- Latency: the write strobe is asserted the cycle after the low byte is accepted. Minimum 3 cycles per word with rx_valid held high.
- index is 16 bits wide. The N > DEPTH check is done on the full 16-bit count, so N = DEPTH is legal and ends at address DEPTH-1 without wrap.
- start while busy (LEN_HI..WRITE) is ignored.
- rx_valid while rx_ready = 0 is not consumed; the source must hold it.
- load_busy = 1 in LEN_HI, LEN_LO, WORD_HI, WORD_LO and WRITE.
- Reset mid-load returns to IDLE with cpu_enable = 0. Memory contents already written are not cleared.

Decomposition:
- Shared package `cpu_pkg`:
  - loader state enum (IDLE, LEN_HI, LEN_LO, WORD_HI, WORD_LO, WRITE, DONE, ERR);
  - INSTR_W = 16 constant;
  - opcode width constant (4), already used by the CPU control path.
- No sub-module; the single FSM plus counters fits in roughly 150–200 lines.
- The top-level integration instantiates prog_loader beside `Team4_CPU` and the instruction RAM.

Test Plan:
- Reset values: assert reset mid-cycle -> all outputs 0 immediately. Release, start pulse -> rx_ready = 1 in LEN_HI.
- Normal 3-word load: bytes 00 03 | 12 34 | AB CD | F0 0F with rx_valid constantly high -> imem_we pulses at addr 0/1/2 with data 1234/ABCD/F00F. load_done and cpu_enable then rise one cycle after the third write.
- Back-pressure/gaps: same stream with rx_valid toggling randomly -> identical writes, no byte dropped or duplicated, and rx_ready never high in WRITE.
- Zero length: 00 00 -> DONE directly, no imem_we ever asserted.
- Overflow: with ADDR_W = 8, count 01 01 (257) -> ERR with load_err = 1, rx_ready = 0, cpu_enable = 0. Count 01 00 (256) -> accepted, last write at addr FF.
- Restart and reset mid-load:
  - start in DONE -> cpu_enable falls that edge and a new load proceeds.
  - reset asserted after word 1 of a 3-word load -> IDLE, load_busy = 0, no further writes.
  - start during WORD_HI -> ignored.
